// File: rtl/color_track_pkg.sv
// Shared types for the colour-blob tracker.
//   rgb565_t     : RGB565 pixel split into its fields
//   region_acc_t : per-region accumulator {bounding box, matched-pixel count}
//   trk_state_t  : frame-commit FSM states
//   mid()        : centre of a span using a carry-safe 11-bit sum
package color_track_pkg;

  localparam int PIX_W     = 10;
  localparam int R_W       = 5;
  localparam int G_W       = 6;
  localparam int B_W       = 5;
  // Accumulator counts are held at a fixed width; the tracker saturates them at
  // its own CNT_W, so the upper bits stay zero.
  localparam int ACC_CNT_W = 32;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [PIX_W-1:0]     x_min;
    logic [PIX_W-1:0]     x_max;
    logic [PIX_W-1:0]     y_min;
    logic [PIX_W-1:0]     y_max;
    logic [ACC_CNT_W-1:0] cnt;
  } region_acc_t;

  // Empty accumulator: min at the top of the range so the first pixel wins.
  localparam region_acc_t ACC_CLR = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0, cnt: '0};

  typedef enum logic [1:0] {SCAN, COMMIT, DONE} trk_state_t;

  function automatic logic [PIX_W-1:0] mid(input logic [PIX_W-1:0] lo, input logic [PIX_W-1:0] hi);
    logic [PIX_W:0] s;
    s = {1'b0, lo} + {1'b0, hi};
    return s[PIX_W:1];
  endfunction

endpackage

// File: rtl/grid_region_index.sv
// Maps a pixel coordinate onto the region grid, purely combinational.
//   i_x, i_y    : pixel column / row
//   o_idx       : row*GRID_COLS + col
//   o_in_frame  : coordinate lies inside H_RES x V_RES
// Column/row come from comparator chains against the cell boundaries; the last
// cell absorbs any remainder of the integer division.
module grid_region_index
  import color_track_pkg::*;
#(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int GRID_COLS = 4,
  parameter int GRID_ROWS = 4,
  parameter int IDX_W     = 4
) (
  input  logic [PIX_W-1:0] i_x,
  input  logic [PIX_W-1:0] i_y,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_in_frame
);

  localparam int CELL_W = H_RES / GRID_COLS;
  localparam int CELL_H = V_RES / GRID_ROWS;

  logic [2:0] w_col, w_row;

  always_comb begin
    w_col = '0;
    w_row = '0;
    for (int k = 1; k < GRID_COLS; k++)
      if (int'(i_x) >= k * CELL_W) w_col = k[2:0];
    for (int k = 1; k < GRID_ROWS; k++)
      if (int'(i_y) >= k * CELL_H) w_row = k[2:0];
    o_idx      = IDX_W'(int'(w_row) * GRID_COLS + int'(w_col));
    o_in_frame = (int'(i_x) < H_RES) && (int'(i_y) < V_RES);
  end

endmodule

// File: rtl/color_grid_tracker.sv
// RGB565 colour-blob tracker. Bins matching pixels into a GRID_COLS x GRID_ROWS
// grid, and on each v_sync rising edge walks the regions one per cycle to publish
// box / centre / count and the strongest region, then pulses o_frame_done.
//   clk, reset            : pixel clock, async active-high reset
//   i_v_sync, i_de        : frame sync (rising edge ends frame), active video
//   i_x_pixel, i_y_pixel  : pixel coordinate
//   i_data                : RGB565 pixel
//   i_thr_*, i_min_pix    : colour thresholds, detection noise floor
//   o_det/o_cx/o_cy/o_b*/o_cnt : per-region results (sample on o_frame_done)
//   o_best_*              : strongest detected region
//   o_frame_done          : one-cycle pulse, all outputs consistent
//   o_target_off          : TIMEOUT_FRAMES consecutive empty frames seen
module color_grid_tracker
  import color_track_pkg::*;
#(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int GRID_COLS      = 4,
  parameter int GRID_ROWS      = 4,
  parameter int CNT_W          = 17,
  parameter int TIMEOUT_FRAMES = 180,
  localparam int N     = GRID_COLS * GRID_ROWS,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_v_sync,
  input  logic                       i_de,
  input  logic [PIX_W-1:0]           i_x_pixel,
  input  logic [PIX_W-1:0]           i_y_pixel,
  input  logic [15:0]                i_data,
  input  logic [R_W-1:0]             i_thr_r_min,
  input  logic [G_W-1:0]             i_thr_g_max,
  input  logic [B_W-1:0]             i_thr_b_max,
  input  logic [CNT_W-1:0]           i_min_pix,
  output logic [N-1:0]               o_det,
  output logic [N-1:0][PIX_W-1:0]    o_cx,
  output logic [N-1:0][PIX_W-1:0]    o_cy,
  output logic [N-1:0][PIX_W-1:0]    o_bx_min,
  output logic [N-1:0][PIX_W-1:0]    o_bx_max,
  output logic [N-1:0][PIX_W-1:0]    o_by_min,
  output logic [N-1:0][PIX_W-1:0]    o_by_max,
  output logic [N-1:0][CNT_W-1:0]    o_cnt,
  output logic                       o_best_valid,
  output logic [IDX_W-1:0]           o_best_idx,
  output logic [PIX_W-1:0]           o_best_x,
  output logic [PIX_W-1:0]           o_best_y,
  output logic                       o_frame_done,
  output logic                       o_target_off
);

  localparam int EMP_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [ACC_CNT_W-1:0] CNT_SAT = ACC_CNT_W'({CNT_W{1'b1}});
  localparam logic [EMP_W-1:0]     EMP_TO  = EMP_W'(TIMEOUT_FRAMES);

  // ---------------- input stage ----------------
  rgb565_t          w_pix;
  logic [IDX_W-1:0] w_idx;
  logic             w_in_frame, w_match;
  logic             r_match, r_vs_d;
  logic [IDX_W-1:0] r_idx;
  logic [PIX_W-1:0] r_x, r_y;

  grid_region_index #(
    .H_RES(H_RES), .V_RES(V_RES), .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS), .IDX_W(IDX_W)
  ) u_idx (
    .i_x(i_x_pixel), .i_y(i_y_pixel), .o_idx(w_idx), .o_in_frame(w_in_frame)
  );

  assign w_pix   = rgb565_t'(i_data);
  assign w_match = i_de & w_in_frame & (w_pix.r > i_thr_r_min) &
                   (w_pix.g < i_thr_g_max) & (w_pix.b < i_thr_b_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match <= 1'b0;
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_vs_d  <= 1'b0;
    end else begin
      r_match <= w_match;
      r_idx   <= w_idx;
      r_x     <= i_x_pixel;
      r_y     <= i_y_pixel;
      r_vs_d  <= i_v_sync;
    end
  end

  logic w_vs_rise;
  assign w_vs_rise = i_v_sync & ~r_vs_d;

  // ---------------- live / shadow banks ----------------
  region_acc_t r_live [N];
  region_acc_t r_shadow [N];
  region_acc_t w_live_nxt [N];

  // On the frame edge the live bank restarts from empty, and a pixel registered
  // in that same cycle lands in the new frame rather than the snapshot.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_live_nxt[i] = w_vs_rise ? ACC_CLR : r_live[i];
      if (r_match && r_idx == IDX_W'(i)) begin
        if (w_live_nxt[i].cnt != CNT_SAT) w_live_nxt[i].cnt = w_live_nxt[i].cnt + 1'b1;
        if (r_x < w_live_nxt[i].x_min) w_live_nxt[i].x_min = r_x;
        if (r_x > w_live_nxt[i].x_max) w_live_nxt[i].x_max = r_x;
        if (r_y < w_live_nxt[i].y_min) w_live_nxt[i].y_min = r_y;
        if (r_y > w_live_nxt[i].y_max) w_live_nxt[i].y_max = r_y;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_live[i]   <= ACC_CLR;
        r_shadow[i] <= ACC_CLR;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_live[i] <= w_live_nxt[i];
        if (w_vs_rise) r_shadow[i] <= r_live[i];
      end
    end
  end

  // ---------------- commit FSM ----------------
  trk_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_i, w_i_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    if (w_vs_rise) begin
      w_state_nxt = COMMIT;
      w_i_nxt     = '0;
    end else begin
      case (r_state)
        COMMIT: if (r_i == IDX_W'(N - 1)) w_state_nxt = DONE;
                else                      w_i_nxt     = r_i + 1'b1;
        DONE:   w_state_nxt = SCAN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SCAN;
      r_i     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
    end
  end

  // A new edge pre-empts the walk: nothing is committed or published that cycle.
  region_acc_t      w_sh;
  logic             w_commit, w_done, w_det, w_better;
  logic [PIX_W-1:0] w_cx, w_cy;

  assign w_sh     = r_shadow[r_i];
  assign w_commit = (r_state == COMMIT) && !w_vs_rise;
  assign w_done   = (r_state == DONE) && !w_vs_rise;
  assign w_det    = w_sh.cnt > ACC_CNT_W'(i_min_pix);
  assign w_cx     = mid(w_sh.x_min, w_sh.x_max);
  assign w_cy     = mid(w_sh.y_min, w_sh.y_max);

  // ---------------- running best ----------------
  logic                 r_run_valid;
  logic [IDX_W-1:0]     r_run_idx;
  logic [ACC_CNT_W-1:0] r_run_cnt;
  logic [PIX_W-1:0]     r_run_cx, r_run_cy;

  // Strict compare keeps the lowest index on a tie; detected implies cnt > 0.
  assign w_better = w_det && (w_sh.cnt > r_run_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_valid <= 1'b0;
      r_run_idx   <= '0;
      r_run_cnt   <= '0;
      r_run_cx    <= '0;
      r_run_cy    <= '0;
    end else if (w_vs_rise) begin
      r_run_valid <= 1'b0;
      r_run_cnt   <= '0;
    end else if (w_commit && w_better) begin
      r_run_valid <= 1'b1;
      r_run_idx   <= r_i;
      r_run_cnt   <= w_sh.cnt;
      r_run_cx    <= w_cx;
      r_run_cy    <= w_cy;
    end
  end

  // ---------------- per-region outputs ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_det    <= '0;
      o_cx     <= '0;
      o_cy     <= '0;
      o_bx_min <= '0;
      o_bx_max <= '0;
      o_by_min <= '0;
      o_by_max <= '0;
      o_cnt    <= '0;
    end else if (w_commit) begin
      o_det[r_i]    <= w_det;
      o_cnt[r_i]    <= w_sh.cnt[CNT_W-1:0];
      o_bx_min[r_i] <= w_det ? w_sh.x_min : '0;
      o_bx_max[r_i] <= w_det ? w_sh.x_max : '0;
      o_by_min[r_i] <= w_det ? w_sh.y_min : '0;
      o_by_max[r_i] <= w_det ? w_sh.y_max : '0;
      o_cx[r_i]     <= w_det ? w_cx : '0;
      o_cy[r_i]     <= w_det ? w_cy : '0;
    end
  end

  // ---------------- frame summary / timeout ----------------
  logic [EMP_W-1:0] r_empty, w_empty_nxt;

  assign w_empty_nxt = r_run_valid       ? '0      :
                       (r_empty == EMP_TO) ? r_empty : r_empty + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_frame_done <= 1'b0;
      o_best_valid <= 1'b0;
      o_best_idx   <= '0;
      o_best_x     <= '0;
      o_best_y     <= '0;
      o_target_off <= 1'b0;
      r_empty      <= '0;
    end else begin
      o_frame_done <= w_done;
      if (w_done) begin
        o_best_valid <= r_run_valid;
        if (r_run_valid) begin
          o_best_idx <= r_run_idx;
          o_best_x   <= r_run_cx;
          o_best_y   <= r_run_cy;
        end
        r_empty      <= w_empty_nxt;
        o_target_off <= (w_empty_nxt == EMP_TO);
      end
    end
  end

endmodule

// File: tb/tb_color_grid_tracker.sv
// Scoreboard bench: stimulus drives pixels and frame edges, a region-level model
// pushes the expected frame report; a monitor pops it on every o_frame_done.
module tb_color_grid_tracker;

  localparam int NR = 16;
  localparam int TO = 3;
  localparam int CMAX = (1 << 17) - 1;

  logic clk = 1'b0;
  logic reset;
  logic i_v_sync, i_de;
  logic [9:0] i_x_pixel, i_y_pixel;
  logic [15:0] i_data;
  logic [4:0] i_thr_r_min;
  logic [5:0] i_thr_g_max;
  logic [4:0] i_thr_b_max;
  logic [16:0] i_min_pix;
  logic [NR-1:0] o_det;
  logic [NR-1:0][9:0] o_cx, o_cy, o_bx_min, o_bx_max, o_by_min, o_by_max;
  logic [NR-1:0][16:0] o_cnt;
  logic o_best_valid;
  logic [3:0] o_best_idx;
  logic [9:0] o_best_x, o_best_y;
  logic o_frame_done, o_target_off;

  color_grid_tracker #(.TIMEOUT_FRAMES(TO)) dut (
    .clk(clk), .reset(reset), .i_v_sync(i_v_sync), .i_de(i_de),
    .i_x_pixel(i_x_pixel), .i_y_pixel(i_y_pixel), .i_data(i_data),
    .i_thr_r_min(i_thr_r_min), .i_thr_g_max(i_thr_g_max), .i_thr_b_max(i_thr_b_max),
    .i_min_pix(i_min_pix), .o_det(o_det), .o_cx(o_cx), .o_cy(o_cy),
    .o_bx_min(o_bx_min), .o_bx_max(o_bx_max), .o_by_min(o_by_min), .o_by_max(o_by_max),
    .o_cnt(o_cnt), .o_best_valid(o_best_valid), .o_best_idx(o_best_idx),
    .o_best_x(o_best_x), .o_best_y(o_best_y), .o_frame_done(o_frame_done),
    .o_target_off(o_target_off)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int det[NR]; int cnt[NR]; int bx0[NR]; int bx1[NR]; int by0[NR]; int by1[NR];
    int cx[NR]; int cy[NR];
    int bv; int bi; int bx; int by; int toff; int cyc;
  } exp_t;
  exp_t q[$];

  int n_vec = 0, n_err = 0, n_done = 0, n_push = 0;

  // ---------------- reference model ----------------
  int thr_r, thr_g, thr_b, min_pix;
  int m_cnt[NR], m_x0[NR], m_x1[NR], m_y0[NR], m_y1[NR];
  int m_bv, m_bi, m_bx, m_by, m_empty;

  task automatic m_clear();
    for (int r = 0; r < NR; r++) begin
      m_cnt[r] = 0; m_x0[r] = 1023; m_x1[r] = 0; m_y0[r] = 1023; m_y1[r] = 0;
    end
  endtask

  task automatic m_add(int x, int y, int d, bit de);
    int r;
    if (de && x < 640 && y < 480 && ((d >> 11) & 31) > thr_r &&
        ((d >> 5) & 63) < thr_g && (d & 31) < thr_b) begin
      r = (y / 120) * 4 + x / 160;
      if (m_cnt[r] < CMAX) m_cnt[r]++;
      if (x < m_x0[r]) m_x0[r] = x;
      if (x > m_x1[r]) m_x1[r] = x;
      if (y < m_y0[r]) m_y0[r] = y;
      if (y > m_y1[r]) m_y1[r] = y;
    end
  endtask

  task automatic m_snap(output exp_t e, input int vc);
    int best = 0;
    bit any = 0;
    for (int r = 0; r < NR; r++) begin
      bit d;
      d = m_cnt[r] > min_pix;
      e.det[r] = d;
      e.cnt[r] = m_cnt[r];
      e.bx0[r] = d ? m_x0[r] : 0;
      e.bx1[r] = d ? m_x1[r] : 0;
      e.by0[r] = d ? m_y0[r] : 0;
      e.by1[r] = d ? m_y1[r] : 0;
      e.cx[r]  = d ? (m_x0[r] + m_x1[r]) / 2 : 0;
      e.cy[r]  = d ? (m_y0[r] + m_y1[r]) / 2 : 0;
      if (d && m_cnt[r] > best) begin
        best = m_cnt[r]; any = 1; m_bi = r; m_bx = e.cx[r]; m_by = e.cy[r];
      end
    end
    m_bv = any;
    m_empty = any ? 0 : ((m_empty < TO) ? m_empty + 1 : TO);
    e.bv = m_bv; e.bi = m_bi; e.bx = m_bx; e.by = m_by;
    e.toff = (m_empty == TO);
    e.cyc = vc + NR + 1;
  endtask

  task automatic m_reset_all();
    m_clear();
    m_bv = 0; m_bi = 0; m_bx = 0; m_by = 0; m_empty = 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(string nm, int r, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (cycle %0d)", nm, r, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && o_frame_done) begin
      n_done++;
      if (q.size() == 0) chk("spurious_frame_done", -1, 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", -1, cyc, e.cyc);
        for (int r = 0; r < NR; r++) begin
          chk("det", r, int'(o_det[r]), e.det[r]);
          chk("cnt", r, int'(o_cnt[r]), e.cnt[r]);
          chk("bx_min", r, int'(o_bx_min[r]), e.bx0[r]);
          chk("bx_max", r, int'(o_bx_max[r]), e.bx1[r]);
          chk("by_min", r, int'(o_by_min[r]), e.by0[r]);
          chk("by_max", r, int'(o_by_max[r]), e.by1[r]);
          chk("cx", r, int'(o_cx[r]), e.cx[r]);
          chk("cy", r, int'(o_cy[r]), e.cy[r]);
        end
        chk("best_valid", -1, int'(o_best_valid), e.bv);
        chk("best_idx", -1, int'(o_best_idx), e.bi);
        chk("best_x", -1, int'(o_best_x), e.bx);
        chk("best_y", -1, int'(o_best_y), e.by);
        chk("target_off", -1, int'(o_target_off), e.toff);
      end
    end
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_det"}, -1, int'(o_det != '0), 0);
    chk({tag, "_centre"}, -1, int'((o_cx != '0) || (o_cy != '0)), 0);
    chk({tag, "_box"}, -1, int'((o_bx_min != '0) || (o_bx_max != '0) ||
                                (o_by_min != '0) || (o_by_max != '0)), 0);
    chk({tag, "_cnt"}, -1, int'(o_cnt != '0), 0);
    chk({tag, "_best"}, -1, int'({o_best_valid, o_best_idx, o_best_x, o_best_y} != '0), 0);
    chk({tag, "_flags"}, -1, int'({o_frame_done, o_target_off} != '0), 0);
  endtask

  // ---------------- stimulus ----------------
  task automatic set_thr(int r, int g, int b, int mp);
    thr_r = r; thr_g = g; thr_b = b; min_pix = mp;
    i_thr_r_min = r[4:0]; i_thr_g_max = g[5:0]; i_thr_b_max = b[4:0]; i_min_pix = mp[16:0];
  endtask

  task automatic drive(int x, int y, int d, bit de);
    i_x_pixel = x[9:0]; i_y_pixel = y[9:0]; i_data = d[15:0]; i_de = de;
  endtask

  task automatic pix(int x, int y, int d, bit de = 1'b1);
    drive(x, y, d, de);
    m_add(x, y, d, de);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    i_de = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic vs_pulse(output int vc);
    i_v_sync = 1'b1; i_de = 1'b0;
    vc = cyc + 1;
    repeat (2) @(negedge clk);
    i_v_sync = 1'b0;
    @(negedge clk);
  endtask

  task automatic finish_frame(int vc);
    exp_t e;
    m_snap(e, vc);
    m_clear();
    q.push_back(e);
    n_push++;
  endtask

  task automatic end_frame();
    int vc;
    idle(2);
    vs_pulse(vc);
    finish_frame(vc);
    repeat (NR + 3) @(negedge clk);
  endtask

  // The pixel driven just before the edge is registered in the edge cycle and
  // therefore belongs to the next frame.
  task automatic end_frame_carry(int x, int y, int d);
    int vc;
    idle(2);
    drive(x, y, d, 1'b1);
    @(negedge clk);
    vs_pulse(vc);
    finish_frame(vc);
    m_add(x, y, d, 1'b1);
    repeat (NR + 3) @(negedge clk);
  endtask

  task automatic block(int x0, int y0, int w, int h, int d);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++) pix(x, y, d);
  endtask

  localparam int RED = 'hF800;

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vc;
    reset = 1'b1; i_v_sync = 1'b0;
    drive(0, 0, 0, 1'b0);
    set_thr(20, 15, 15, 30);
    m_reset_all();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // 20x20 red square in region 0
    block(100, 50, 20, 20, RED);
    end_frame();

    // equal blobs in regions 5 and 10, then region 10 one larger
    block(170, 130, 25, 20, RED);
    block(330, 250, 25, 20, RED);
    end_frame();
    block(170, 130, 25, 20, RED);
    block(330, 250, 25, 20, RED);
    pix(355, 250, RED);
    end_frame();

    // noise floor boundary in region 3
    block(500, 10, 30, 1, RED);
    end_frame();
    block(500, 10, 31, 1, RED);
    end_frame();
    set_thr(20, 15, 15, 40);
    block(500, 10, 31, 1, RED);
    end_frame();

    // colour threshold / frame / DE boundaries, then a carried pixel
    set_thr(20, 15, 15, 0);
    pix(10, 10, (21 << 11) | (14 << 5) | 14);
    pix(11, 10, (20 << 11) | (14 << 5) | 14);
    pix(20, 10, (21 << 11) | (15 << 5) | 14);
    pix(640, 10, RED);
    pix(12, 479, RED);
    pix(13, 480, RED);
    pix(14, 10, RED, 1'b0);
    end_frame_carry(200, 200, RED);
    end_frame();

    // target-lost timeout
    set_thr(20, 15, 15, 30);
    block(600, 400, 8, 8, RED);
    end_frame();
    repeat (3) end_frame();
    block(600, 400, 8, 8, RED);
    end_frame();

    // async reset during active video
    block(100, 50, 10, 10, RED);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    m_reset_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    block(400, 300, 7, 6, RED);
    end_frame();

    // second edge during COMMIT restarts the walk; one frame_done follows
    block(100, 50, 10, 10, RED);
    idle(2);
    vs_pulse(vc);
    m_clear();
    pix(330, 250, RED);
    pix(340, 260, RED);
    pix(350, 255, RED);
    end_frame();

    // randomized frames
    for (int f = 0; f < 16; f++) begin
      int hr, hx, hy, d;
      set_thr($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 31),
              $urandom_range(0, 3));
      if (f % 5 != 4) begin
        hr = $urandom_range(0, NR - 1);
        hx = (hr % 4) * 160 + $urandom_range(0, 139);
        hy = (hr / 4) * 120 + $urandom_range(0, 99);
        for (int k = 0; k < 60; k++) begin
          d = ($urandom_range(16, 31) << 11) | ($urandom_range(0, 20) << 5) | $urandom_range(0, 20);
          pix(hx + $urandom_range(0, 19), hy + $urandom_range(0, 19), d);
        end
        for (int k = 0; k < 120; k++)
          pix($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 65535),
              $urandom_range(0, 9) != 0);
      end
      if (f % 4 == 3) end_frame_carry($urandom_range(0, 639), $urandom_range(0, 479), RED);
      else end_frame();
    end
    end_frame();

    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
    chk("pending_frames", -1, q.size(), 0);
    chk("frame_done_count", -1, n_done, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
